commit_trace_buffer: RTL and testbench

Synthesizable retirement-trace unit for the single-cycle RISC-V core: captures every committed register write-back with cycle stamp and PC, buffers records in a parametrised FIFO, and streams them out over a valid/ready port. It replaces per-cycle full-register-file dumps with a compact, backpressure-aware, change-only trace that works in simulation and on hardware.

---
 rtl/commit_trace_buffer.sv | 104 ++++++++++
 tb/tb_commit_trace_buffer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/commit_trace_buffer.sv
// Retirement-trace unit: stamps committed register write-backs and streams them
// through a first-word fall-through FIFO. Optional TRACE_CHANGED_ONLY_EN drops value-unchanged rewrites.
module commit_trace_buffer #(
  parameter int XLEN  = 32,
  parameter int NREG  = 32,
  parameter int DEPTH = 16,
  parameter int CYC_W = 32,
  localparam int RW   = $clog2(NREG),
  localparam int LW   = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             commit_valid,
  input  logic             commit_we,
  input  logic [RW-1:0]    commit_rd,
  input  logic [XLEN-1:0]  commit_wdata,
  input  logic [XLEN-1:0]  commit_pc,
  output logic             trace_valid,
  input  logic             trace_ready,
  output logic [CYC_W-1:0] trace_cycle,
  output logic [XLEN-1:0]  trace_pc,
  output logic [RW-1:0]    trace_rd,
  output logic [XLEN-1:0]  trace_data,
  input  logic             clr_ovf,
  output logic             overflow,
  output logic [15:0]      drop_cnt,
  output logic [LW-1:0]    level
);

  localparam int AW = LW - 1;

  typedef struct packed {
    logic [CYC_W-1:0] cyc;
    logic [XLEN-1:0]  pc;
    logic [RW-1:0]    rd;
    logic [XLEN-1:0]  data;
  } rec_t;

  rec_t             mem [DEPTH];
  rec_t             head;
  logic [LW-1:0]    wptr, rptr;
  logic [CYC_W-1:0] cyc_cnt;
  logic             cand, want, full, empty, pop, push, drop;

  assign cand  = commit_valid & commit_we & (commit_rd != '0);
  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign pop   = trace_valid & trace_ready;
  assign push  = want & (~full | pop);
  assign drop  = want & full & ~pop;
  assign level = wptr - rptr;

`ifdef TRACE_CHANGED_ONLY_EN
  logic [XLEN-1:0] shadow [NREG];

  assign want = cand & (commit_wdata != shadow[commit_rd]);

  // Shadow is architecturally visible (it decides filtering), so it must reset to 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) shadow[i] <= '0;
    end else if (cand) begin
      shadow[commit_rd] <= commit_wdata;
    end
  end
`else
  assign want = cand;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_cnt  <= '0;
      wptr     <= '0;
      rptr     <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      cyc_cnt <= cyc_cnt + 1'b1;
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      if (clr_ovf) begin
        overflow <= 1'b0;
        drop_cnt <= '0;
      end else if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      end
    end
  end

  // NOTE: FIFO storage is deliberately not reset; empty pointers plus output gating hide stale entries.
  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= '{cyc: cyc_cnt, pc: commit_pc, rd: commit_rd, data: commit_wdata};
  end

  assign head        = mem[rptr[AW-1:0]];
  assign trace_valid = ~empty;
  assign trace_cycle = trace_valid ? head.cyc  : '0;
  assign trace_pc    = trace_valid ? head.pc   : '0;
  assign trace_rd    = trace_valid ? head.rd   : '0;
  assign trace_data  = trace_valid ? head.data : '0;

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Self-checking bench for commit_trace_buffer: directed scenarios plus randomized traffic
// compared every cycle against a queue-based reference model.
module tb_commit_trace_buffer;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        commit_valid, commit_we, trace_ready, clr_ovf;
  logic [4:0]  commit_rd;
  logic [31:0] commit_wdata, commit_pc;
  logic        trace_valid, overflow;
  logic [31:0] trace_cycle, trace_pc, trace_data;
  logic [4:0]  trace_rd;
  logic [15:0] drop_cnt;
  logic [4:0]  level;

  commit_trace_buffer #(.XLEN(32), .NREG(32), .DEPTH(DEPTH), .CYC_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .commit_valid(commit_valid), .commit_we(commit_we), .commit_rd(commit_rd),
    .commit_wdata(commit_wdata), .commit_pc(commit_pc),
    .trace_valid(trace_valid), .trace_ready(trace_ready),
    .trace_cycle(trace_cycle), .trace_pc(trace_pc), .trace_rd(trace_rd), .trace_data(trace_data),
    .clr_ovf(clr_ovf), .overflow(overflow), .drop_cnt(drop_cnt), .level(level)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] cyc;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] data;
  } rec_t;

  // Reference model state
  rec_t        q[$];
  logic [31:0] m_cyc;
  logic        m_ovf;
  int          m_drops;
  logic [31:0] m_shadow [32];

  int tests = 0;
  int fails = 0;

  task automatic model_reset();
    q.delete();
    m_cyc   = 0;
    m_ovf   = 1'b0;
    m_drops = 0;
    for (int i = 0; i < 32; i++) m_shadow[i] = 0;
  endtask

  // Drives one cycle, compares DUT outputs with the model, then advances the model at the edge.
  task automatic step(input logic v, input logic we, input logic [4:0] rd, input logic [31:0] wd,
                      input logic [31:0] pc, input logic rdy, input logic clr);
    rec_t h;
    bit   cand, want, was_full, do_pop;
    commit_valid = v; commit_we = we; commit_rd = rd; commit_wdata = wd; commit_pc = pc;
    trace_ready = rdy; clr_ovf = clr;
    #3;
    h = (q.size() != 0) ? q[0] : '0;
    tests++;
    if (trace_valid !== (q.size() != 0) || trace_cycle !== h.cyc || trace_pc !== h.pc ||
        trace_rd !== h.rd || trace_data !== h.data || level !== 5'(q.size()) ||
        overflow !== m_ovf || drop_cnt !== 16'(m_drops)) begin
      fails++;
      $display("FAIL model_cycle t=%0t: got valid=%b cyc=%0d pc=%h rd=%0d data=%h level=%0d ovf=%b drops=%0d; want valid=%b cyc=%0d pc=%h rd=%0d data=%h level=%0d ovf=%b drops=%0d",
               $time, trace_valid, trace_cycle, trace_pc, trace_rd, trace_data, level, overflow, drop_cnt,
               q.size() != 0, h.cyc, h.pc, h.rd, h.data, q.size(), m_ovf, m_drops);
    end
    @(posedge clk);
    do_pop   = (q.size() != 0) && rdy;
    was_full = (q.size() == DEPTH);
    cand     = v && we && (rd != 0);
    want     = cand;
`ifdef TRACE_CHANGED_ONLY_EN
    want = cand && (wd != m_shadow[rd]);
    if (cand) m_shadow[rd] = wd;
`endif
    if (do_pop) void'(q.pop_front());
    if (want && (!was_full || do_pop)) q.push_back('{cyc: m_cyc, pc: pc, rd: rd, data: wd});
    if (clr) begin
      m_ovf = 1'b0; m_drops = 0;
    end else if (want && was_full && !do_pop) begin
      m_ovf = 1'b1;
      if (m_drops < 16'hFFFF) m_drops++;
    end
    m_cyc++;
    #1;
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 1'b0, 5'd0, 32'd0, 32'd0, rdy, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    commit_valid = 0; commit_we = 0; commit_rd = 0; commit_wdata = 0; commit_pc = 0;
    trace_ready = 0; clr_ovf = 0;
    @(posedge clk); #1;
    model_reset();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if (trace_valid !== 1'b0 || level !== 5'd0 || overflow !== 1'b0 || drop_cnt !== 16'd0 ||
        trace_cycle !== 32'd0 || trace_data !== 32'd0 || trace_pc !== 32'd0 || trace_rd !== 5'd0) begin
      fails++;
      $display("FAIL reset_state: got valid=%b level=%0d ovf=%b drops=%0d cyc=%0d data=%h, want all zero",
               trace_valid, level, overflow, drop_cnt, trace_cycle, trace_data);
    end
  endtask

  task automatic test_single_write();
    do_reset();
    repeat (3) idle(1'b0);
    step(1'b1, 1'b1, 5'd5, 32'h14, 32'h0, 1'b0, 1'b0);
    tests++;
    if (trace_valid !== 1'b1 || trace_cycle !== 32'd3 || trace_pc !== 32'h0 ||
        trace_rd !== 5'd5 || trace_data !== 32'h14 || level !== 5'd1) begin
      fails++;
      $display("FAIL single_write: got valid=%b cyc=%0d pc=%h rd=%0d data=%h level=%0d, want 1 3 0 5 14 1",
               trace_valid, trace_cycle, trace_pc, trace_rd, trace_data, level);
    end
    idle(1'b1);
  endtask

  task automatic test_x0_filter();
    do_reset();
    step(1'b1, 1'b1, 5'd0, 32'hDEAD_BEEF, 32'h40, 1'b0, 1'b0);
    tests++;
    if (trace_valid !== 1'b0 || level !== 5'd0) begin
      fails++;
      $display("FAIL x0_filter: got valid=%b level=%0d, want 0 0", trace_valid, level);
    end
    idle(1'b0);
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 18; i++) step(1'b1, 1'b1, 5'((i % 31) + 1), 32'h1000 + i, 32'(4 * i), 1'b0, 1'b0);
    tests++;
    if (level !== 5'd16 || overflow !== 1'b1 || drop_cnt !== 16'd2) begin
      fails++;
      $display("FAIL overflow: got level=%0d ovf=%b drops=%0d, want 16 1 2", level, overflow, drop_cnt);
    end
    step(1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b1);
    tests++;
    if (overflow !== 1'b0 || drop_cnt !== 16'd0 || level !== 5'd16) begin
      fails++;
      $display("FAIL clr_ovf: got ovf=%b drops=%0d level=%0d, want 0 0 16", overflow, drop_cnt, level);
    end
    for (int i = 0; i < 16; i++) begin
      tests++;
      if (trace_data !== 32'h1000 + i || trace_cycle !== 32'(i)) begin
        fails++;
        $display("FAIL drain_order[%0d]: got data=%h cyc=%0d, want %h %0d", i, trace_data, trace_cycle, 32'h1000 + i, i);
      end
      idle(1'b1);
    end
    tests++;
    if (level !== 5'd0 || trace_valid !== 1'b0) begin
      fails++;
      $display("FAIL drain_empty: got level=%0d valid=%b, want 0 0", level, trace_valid);
    end
  endtask

  task automatic test_full_pop();
    do_reset();
    for (int i = 0; i < 16; i++) step(1'b1, 1'b1, 5'(i + 1), 32'h2000 + i, 32'h100, 1'b0, 1'b0);
    step(1'b1, 1'b1, 5'd20, 32'h2FFF, 32'h200, 1'b1, 1'b0);
    tests++;
    if (level !== 5'd16 || drop_cnt !== 16'd0 || overflow !== 1'b0 || trace_data !== 32'h2001) begin
      fails++;
      $display("FAIL full_pop: got level=%0d drops=%0d ovf=%b head=%h, want 16 0 0 2001", level, drop_cnt, overflow, trace_data);
    end
    repeat (17) idle(1'b1);
  endtask

  task automatic test_changed_only();
    int exp_n;
`ifdef TRACE_CHANGED_ONLY_EN
    exp_n = 2;
`else
    exp_n = 3;
`endif
    do_reset();
    step(1'b1, 1'b1, 5'd7, 32'h5, 32'h10, 1'b0, 1'b0);
    step(1'b1, 1'b1, 5'd7, 32'h5, 32'h14, 1'b0, 1'b0);
    step(1'b1, 1'b1, 5'd7, 32'h6, 32'h18, 1'b0, 1'b0);
    tests++;
    if (level !== 5'(exp_n)) begin
      fails++;
      $display("FAIL changed_only_count: got level=%0d, want %0d", level, exp_n);
    end
    repeat (4) idle(1'b1);
  endtask

  task automatic test_reset_midstream();
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 5'd3, 32'h30 + i, 32'h0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    tests++;
    if (trace_valid !== 1'b0 || level !== 5'd0 || trace_data !== 32'd0) begin
      fails++;
      $display("FAIL async_reset: got valid=%b level=%0d data=%h, want 0 0 0", trace_valid, level, trace_data);
    end
    @(posedge clk); #1;
    model_reset();
    rst_n = 1'b1;
    step(1'b1, 1'b1, 5'd9, 32'h99, 32'h80, 1'b0, 1'b0);
    tests++;
    if (trace_valid !== 1'b1 || trace_cycle !== 32'd0 || trace_data !== 32'h99) begin
      fails++;
      $display("FAIL cycle_restart: got valid=%b cyc=%0d data=%h, want 1 0 99", trace_valid, trace_cycle, trace_data);
    end
    idle(1'b1);
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 9) < 7, $urandom_range(0, 3) != 0, 5'($urandom_range(0, 3)),
           32'($urandom_range(0, 3)), $urandom, $urandom_range(0, 9) < 4, $urandom_range(0, 39) == 0);
    end
    repeat (DEPTH + 2) idle(1'b1);
  endtask

  initial begin
    rst_n = 1'b0;
    #2;
    test_reset();
    test_single_write();
    test_x0_filter();
    test_overflow();
    test_full_pop();
    test_changed_only();
    test_reset_midstream();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
